// File: rtl/alu_op_sequencer.sv
// Request/response controller for a combinational 3-op-select ALU: registers operands,
// waits a fixed settle time, captures result/flags and returns them with backpressure.
module alu_op_sequencer #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_sel,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_prev,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic [2:0]       rsp_sel,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  wait_cnt;
  logic [WIDTH-1:0] acc;
  logic           accept;
  logic           capture;
  logic           done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          capture    = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          done       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // req_ready depends on state only; gated low while reset is held.
  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      acc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_sel    <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_a    <= req_use_prev ? acc : req_a;
        alu_b    <= req_b;
        alu_sel  <= req_sel;
        wait_cnt <= CW'(SETTLE_CYCLES - 1);
      end else if (state == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - CW'(1);
      end

      if (capture) begin
        rsp_result <= alu_result;
        rsp_z      <= alu_z;
        // Overflow is only meaningful for ADD/SUB.
        rsp_v      <= (alu_sel == 3'b100 || alu_sel == 3'b101) ? alu_v : 1'b0;
        rsp_sel    <= alu_sel;
        acc        <= alu_result;
        rsp_valid  <= 1'b1;
      end

      if (done) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table on a SETTLE=1 instance plus
// hand sequences for backpressure, mid-op reset and a SETTLE=3 counter-wrap run.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference ALU behaviour: returns {v, z, result}
  function automatic logic [4:0] alu_f(input logic [2:0] s, input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    logic v;
    v = 1'b0;
    case (s)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a ^ b;
      3'b011: r = ~b;
      3'b100: begin r = a + b; v = (a[2] == b[2]) && (r[2] != a[2]); end
      3'b101: begin r = a - b; v = (a[2] != b[2]) && (r[2] != a[2]); end
      3'b110: begin r = b + 3'd1; v = (b == 3'b011); end
      default: begin r = 3'd0 - a; v = (a == 3'b100); end
    endcase
    return {v, (r == 3'b000), r};
  endfunction

  // ---------------- DUT 1: SETTLE_CYCLES=1 ----------------
  logic rst1 = 1'b1;
  logic d1_req_valid = 1'b0, d1_req_ready, d1_req_use_prev = 1'b0;
  logic [2:0] d1_req_sel = '0, d1_req_a = '0, d1_req_b = '0;
  logic [2:0] d1_alu_a, d1_alu_b, d1_alu_sel, d1_alu_result;
  logic d1_alu_z, d1_alu_v, force_v = 1'b0;
  logic d1_rsp_valid, d1_rsp_ready = 1'b0, d1_rsp_z, d1_rsp_v, d1_busy;
  logic [2:0] d1_rsp_result, d1_rsp_sel;
  logic [7:0] d1_op_count;
  logic [4:0] d1_alu_out;

  assign d1_alu_out    = alu_f(d1_alu_sel, d1_alu_a, d1_alu_b);
  assign d1_alu_result = d1_alu_out[2:0];
  assign d1_alu_z      = d1_alu_out[3];
  assign d1_alu_v      = d1_alu_out[4] | force_v;

  alu_op_sequencer #(.WIDTH(3), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst1),
    .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_sel(d1_req_sel),
    .req_a(d1_req_a), .req_b(d1_req_b), .req_use_prev(d1_req_use_prev),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_sel(d1_alu_sel),
    .alu_result(d1_alu_result), .alu_z(d1_alu_z), .alu_v(d1_alu_v),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_result(d1_rsp_result),
    .rsp_z(d1_rsp_z), .rsp_v(d1_rsp_v), .rsp_sel(d1_rsp_sel),
    .busy(d1_busy), .op_count(d1_op_count)
  );

  // ---------------- DUT 2: SETTLE_CYCLES=3 ----------------
  logic rst2 = 1'b1;
  logic d2_req_valid = 1'b0, d2_req_ready, d2_req_use_prev = 1'b0;
  logic [2:0] d2_req_sel = '0, d2_req_a = '0, d2_req_b = '0;
  logic [2:0] d2_alu_a, d2_alu_b, d2_alu_sel, d2_alu_result;
  logic d2_alu_z, d2_alu_v;
  logic d2_rsp_valid, d2_rsp_ready = 1'b0, d2_rsp_z, d2_rsp_v, d2_busy;
  logic [2:0] d2_rsp_result, d2_rsp_sel;
  logic [7:0] d2_op_count;

  assign {d2_alu_v, d2_alu_z, d2_alu_result} = alu_f(d2_alu_sel, d2_alu_a, d2_alu_b);

  alu_op_sequencer #(.WIDTH(3), .SETTLE_CYCLES(3), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst2),
    .req_valid(d2_req_valid), .req_ready(d2_req_ready), .req_sel(d2_req_sel),
    .req_a(d2_req_a), .req_b(d2_req_b), .req_use_prev(d2_req_use_prev),
    .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_sel(d2_alu_sel),
    .alu_result(d2_alu_result), .alu_z(d2_alu_z), .alu_v(d2_alu_v),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_result(d2_rsp_result),
    .rsp_z(d2_rsp_z), .rsp_v(d2_rsp_v), .rsp_sel(d2_rsp_sel),
    .busy(d2_busy), .op_count(d2_op_count)
  );

  typedef struct {
    logic [2:0] sel;
    logic [2:0] a;
    logic [2:0] b;
    logic       use_prev;
    logic       force_v;
    logic [2:0] exp_alu_a;
    logic [2:0] exp_res;
    logic       exp_z;
    logic       exp_v;
  } vec_t;

  vec_t vecs[12];
  int   exp_cnt1 = 0;

  // Called at a negedge with DUT1 idle; returns at a negedge with DUT1 idle again.
  task automatic do_op1(input int idx, input vec_t v);
    int n;
    chk($sformatf("v%0d_req_ready", idx), d1_req_ready, 1);
    d1_req_valid    = 1'b1;
    d1_req_sel      = v.sel;
    d1_req_a        = v.a;
    d1_req_b        = v.b;
    d1_req_use_prev = v.use_prev;
    d1_rsp_ready    = 1'b1;
    force_v         = v.force_v;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      d1_req_valid = 1'b0;
      n++;
      if (n == 1) begin
        chk($sformatf("v%0d_alu_a", idx), d1_alu_a, v.exp_alu_a);
        chk($sformatf("v%0d_alu_b", idx), d1_alu_b, v.b);
        chk($sformatf("v%0d_alu_sel", idx), d1_alu_sel, v.sel);
        chk($sformatf("v%0d_ready_wait", idx), d1_req_ready, 0);
      end
    end while (!d1_rsp_valid && n < 20);
    chk($sformatf("v%0d_latency", idx), n, 2);
    chk($sformatf("v%0d_result", idx), d1_rsp_result, v.exp_res);
    chk($sformatf("v%0d_z", idx), d1_rsp_z, v.exp_z);
    chk($sformatf("v%0d_v", idx), d1_rsp_v, v.exp_v);
    chk($sformatf("v%0d_sel", idx), d1_rsp_sel, v.sel);
    exp_cnt1++;
    @(negedge clk);
    force_v = 1'b0;
    chk($sformatf("v%0d_valid_drop", idx), d1_rsp_valid, 0);
    chk($sformatf("v%0d_busy_drop", idx), d1_busy, 0);
    chk($sformatf("v%0d_op_count", idx), d1_op_count, exp_cnt1 % 256);
  endtask

  initial begin
    int n;
    vec_t hv;
    logic [2:0] ai;

    vecs[0]  = '{3'b100, 3'b011, 3'b010, 1'b0, 1'b0, 3'b011, 3'b101, 1'b0, 1'b1};
    vecs[1]  = '{3'b101, 3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 3'b111, 3'b101, 1'b0, 1'b1, 3'b111, 3'b101, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 3'b001, 3'b001, 1'b0, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 3'b111, 3'b001, 1'b1, 1'b0, 3'b010, 3'b011, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 3'b100, 3'b001, 1'b0, 1'b0, 3'b100, 3'b101, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 3'b110, 3'b011, 1'b0, 1'b0, 3'b110, 3'b101, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 3'b000, 3'b010, 1'b0, 1'b0, 3'b000, 3'b101, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 3'b000, 3'b011, 1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0};
    vecs[9]  = '{3'b111, 3'b100, 3'b000, 1'b0, 1'b0, 3'b100, 3'b100, 1'b0, 1'b0};
    vecs[10] = '{3'b101, 3'b100, 3'b001, 1'b0, 1'b0, 3'b100, 3'b011, 1'b0, 1'b1};
    vecs[11] = '{3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 3'b011, 3'b101, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", d1_req_ready, 0);
    chk("rst_rsp_valid", d1_rsp_valid, 0);
    chk("rst_busy", d1_busy, 0);
    chk("rst_alu_a", d1_alu_a, 0);
    chk("rst_op_count", d1_op_count, 0);
    rst1 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", d1_req_ready, 1);

    for (int i = 0; i < 12; i++) do_op1(i, vecs[i]);

    // Backpressure: hold rsp_ready low for 5 cycles after response appears
    d1_req_valid = 1'b1; d1_req_sel = 3'b100; d1_req_a = 3'b001; d1_req_b = 3'b010;
    d1_req_use_prev = 1'b0; d1_rsp_ready = 1'b0;
    @(posedge clk);
    n = 0;
    do begin @(negedge clk); d1_req_valid = 1'b0; n++; end while (!d1_rsp_valid && n < 20);
    chk("bp_latency", n, 2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", d1_rsp_valid, 1);
      chk("bp_result", d1_rsp_result, 3);
      chk("bp_sel", d1_rsp_sel, 4);
      chk("bp_req_ready", d1_req_ready, 0);
      chk("bp_busy", d1_busy, 1);
      chk("bp_count_hold", d1_op_count, exp_cnt1);
      @(negedge clk);
    end
    d1_rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt1++;
    chk("bp_release_busy", d1_busy, 0);
    chk("bp_release_valid", d1_rsp_valid, 0);
    chk("bp_release_count", d1_op_count, exp_cnt1);
    chk("bp_result_kept", d1_rsp_result, 3);

    // Reset during WAIT drops the op and clears acc/op_count
    d1_req_valid = 1'b1; d1_req_sel = 3'b100; d1_req_a = 3'b011; d1_req_b = 3'b001;
    @(posedge clk);
    @(negedge clk);
    d1_req_valid = 1'b0;
    chk("mid_busy_before", d1_busy, 1);
    rst1 = 1'b1;
    #1;
    chk("mid_rst_req_ready", d1_req_ready, 0);
    chk("mid_rst_busy", d1_busy, 0);
    chk("mid_rst_alu_a", d1_alu_a, 0);
    chk("mid_rst_alu_b", d1_alu_b, 0);
    chk("mid_rst_alu_sel", d1_alu_sel, 0);
    chk("mid_rst_rsp_result", d1_rsp_result, 0);
    chk("mid_rst_op_count", d1_op_count, 0);
    @(negedge clk);
    rst1 = 1'b0;
    exp_cnt1 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("after_rst_no_rsp", d1_rsp_valid, 0);
    end
    hv = '{3'b100, 3'b101, 3'b001, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0};
    do_op1(100, hv);

    // SETTLE_CYCLES=3: 257 back-to-back ops, counter wraps to 1
    for (int i = 0; i < 257; i++) begin
      ai = 3'(i);
      d2_req_valid = 1'b1; d2_req_sel = 3'b100; d2_req_a = ai; d2_req_b = 3'b001;
      d2_rsp_ready = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
        @(negedge clk);
        d2_req_valid = 1'b0;
        n++;
        if (!d2_rsp_valid) chk("s3_alu_a_stable", d2_alu_a, ai);
      end while (!d2_rsp_valid && n < 20);
      chk("s3_latency", n, 4);
      chk("s3_result", d2_rsp_result, 3'(ai + 3'd1));
      @(negedge clk);
      chk("s3_op_count", d2_op_count, (i + 1) % 256);
    end
    chk("s3_final_count", d2_op_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
